imem_arb: RTL and testbench
===========================

# imem_arb

Two-port arbiter and sequencer for the single read port of the instruction ROM (4096 × 32-bit words, combinational read, 64-bit byte address). It shares that port between the fetch stage and a debug/loader read port. Each requester uses a valid/ready request and response handshake. Requests are granted round-robin, the ROM word is captured into a response register, and out-of-range accesses are flagged instead of silently returning zero.

## Interface
Parameters:
- ADDR_W, 64, byte-address width of requests and of the ROM address.
- DATA_W, 32, instruction word width.
- DEPTH_LOG2, 12, log2 of ROM word count; valid byte range is 0 .. 2^(DEPTH_LOG2+2)-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req_valid  in  1  fetch request valid.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  ADDR_W  fetch byte address.
- if_rsp_valid  out  1  fetch response valid.
- if_rsp_ready  in  1  fetch consumer takes response.
- if_rsp_data  out  DATA_W  fetched word.
- if_rsp_err  out  1  fetch address out of range or misaligned.
- dbg_req_valid, dbg_req_ready, dbg_req_addr, dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_data, dbg_rsp_err: same directions, widths and meaning for the debug port.
- rom_addr  out  ADDR_W  address driven to ROM (registered).
- rom_dout  in  DATA_W  ROM combinational read data.

## Operation
- FSM with three states:
  - IDLE → READ on acceptance of a request.
  - READ → RESP unconditionally.
  - RESP → IDLE when the owner's rsp_ready=1 while rsp_valid=1.
- Arbitration happens in IDLE only:
  - If exactly one req_valid is high, that port is granted.
  - If both are high, the port not granted last is granted.
  - `last_grant` resets to DBG, so fetch wins the first contention.
- `x_req_ready = (state==IDLE) && grant==x`, combinational from the valids. At most one req_ready is high per cycle.
- On acceptance, latch the address into `addr_q` and the winning port into `owner_q`, and update `last_grant`.
- rom_addr = addr_q at all times.
- In READ:
  - Compute `err = (addr_q[ADDR_W-1:DEPTH_LOG2+2] != 0)`, OR-ed with the alignment check when it is compiled in.
  - Capture `data_q = err ? 0 : rom_dout`, and `err_q = err`.
- In RESP:
  - Only the owner's rsp_valid=1; its rsp_data=data_q and rsp_err=err_q.
  - Hold all three stable until rsp_ready=1.
  - The non-owner's rsp_valid/data/err are 0.
- Requests arriving outside IDLE see req_ready=0. Requesters must hold valid and address stable until ready.
- No request is dropped: a waiting port is granted at the latest in the second IDLE cycle after the current owner's response completes.

## Timing
- Reset values (asynchronous on rst_n=0):
  - state=IDLE, last_grant=DBG, rom_addr=0, data_q=0, err_q=0.
  - All rsp_valid/rsp_data/rsp_err = 0.
- Reset mid-transaction aborts it; no response is ever delivered for the aborted request.
- Latency: request accepted at edge N (valid & ready high in cycle N-1) → state READ in cycle N → rsp_valid=1 in cycle N+1 (data sampled from rom_dout during cycle N).
- With rsp_ready held high, throughput is one access per 3 cycles: IDLE, READ, RESP.
- Simultaneous rsp handshake and new request: the new request is seen in the following IDLE cycle, not in the RESP cycle.
- Address boundaries:
  - Highest valid address, 0x3FFC with DEPTH_LOG2=12: err=0.
  - 0x4000: err=1, data=0.
  - Any set bit above bit 13: err=1.

## Configuration
- IMEM_ARB_ALIGN_CHECK_EN defined:
  - addr_q[1:0] != 0 sets err=1 and data=0.
- Undefined:
  - Bits [1:0] are ignored; the word at addr_q[DEPTH_LOG2+1:2] is returned with err set only by the range check.

## Test plan
- Reset: assert rst_n=0 mid-RESP → all rsp_valid=0, rom_addr=0; after release, no stale response appears.
- Single fetch: if_req_addr=0x8 with ROM word 2=0x00500093, rsp_ready=1 → if_rsp_valid one cycle, 2 cycles after acceptance, data=0x00500093, err=0.
- Contention: both valid at the same time with addrs 0x0 and 0x4 → IF granted first. Still both valid after IF completes → DBG granted next. Then IF again: alternation is verified over 6 transactions.
- Backpressure: dbg_rsp_ready=0 for 5 cycles → dbg_rsp_valid/data stay stable, if_req_ready stays 0 throughout, and IF is granted in the cycle after the DBG handshake completes.
- Range: address 0x3FFC → err=0 with word 4095. Addresses 0x4000 and 0x1_0000_0000 → err=1, data=0.
- Alignment: address 0x6.
  - With IMEM_ARB_ALIGN_CHECK_EN: err=1, data=0.
  - Without it: err=0, data=word 1.

Source files
------------

// File: rtl/imem_arb.sv
// Round-robin arbiter/sequencer sharing the instruction ROM read port between fetch and debug.
// Optional misaligned-address error: define IMEM_ARB_ALIGN_CHECK_EN.
module imem_arb #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_req_addr,
  output logic              if_rsp_valid,
  input  logic              if_rsp_ready,
  output logic [DATA_W-1:0] if_rsp_data,
  output logic              if_rsp_err,
  input  logic              dbg_req_valid,
  output logic              dbg_req_ready,
  input  logic [ADDR_W-1:0] dbg_req_addr,
  output logic              dbg_rsp_valid,
  input  logic              dbg_rsp_ready,
  output logic [DATA_W-1:0] dbg_rsp_data,
  output logic              dbg_rsp_err,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic P_IF  = 1'b0;
  localparam logic P_DBG = 1'b1;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_owner_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic [DATA_W-1:0]   r_data_q;
  logic                r_err_q;

  logic                w_grant_dbg;
  logic                w_accept;
  logic                w_range_err;
  logic                w_align_err;
  logic                w_err;
  logic                w_rsp_hs;
  logic                w_if_own;
  logic                w_dbg_own;

  // Debug wins only when fetch is idle or fetch was served last.
  assign w_grant_dbg   = dbg_req_valid && (!if_req_valid || (r_last_grant == P_IF));
  assign if_req_ready  = (r_state == S_IDLE) && if_req_valid && !w_grant_dbg;
  assign dbg_req_ready = (r_state == S_IDLE) && w_grant_dbg;
  assign w_accept      = if_req_ready || dbg_req_ready;

  assign w_range_err = |r_addr_q[ADDR_W-1:DEPTH_LOG2+2];
`ifdef IMEM_ARB_ALIGN_CHECK_EN
  assign w_align_err = |r_addr_q[1:0];
`else
  assign w_align_err = 1'b0;
`endif
  assign w_err = w_range_err || w_align_err;

  assign w_if_own  = (r_state == S_RESP) && (r_owner_q == P_IF);
  assign w_dbg_own = (r_state == S_RESP) && (r_owner_q == P_DBG);
  assign w_rsp_hs  = (w_if_own && if_rsp_ready) || (w_dbg_own && dbg_rsp_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_READ;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_READ: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (w_rsp_hs) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Request capture on acceptance and ROM word capture in READ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= P_DBG;
      r_owner_q    <= P_IF;
      r_addr_q     <= '0;
      r_data_q     <= '0;
      r_err_q      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner_q    <= w_grant_dbg;
        r_last_grant <= w_grant_dbg;
        r_addr_q     <= w_grant_dbg ? dbg_req_addr : if_req_addr;
      end
      if (r_state == S_READ) begin
        r_data_q <= w_err ? '0 : rom_dout;
        r_err_q  <= w_err;
      end
    end
  end

  assign rom_addr = r_addr_q;

  // Non-owner response outputs are forced to zero.
  assign if_rsp_valid  = w_if_own;
  assign if_rsp_data   = w_if_own ? r_data_q : '0;
  assign if_rsp_err    = w_if_own && r_err_q;
  assign dbg_rsp_valid = w_dbg_own;
  assign dbg_rsp_data  = w_dbg_own ? r_data_q : '0;
  assign dbg_rsp_err   = w_dbg_own && r_err_q;

endmodule

// File: tb/tb_imem_arb.sv
// Directed bench for imem_arb: reset, contention, backpressure, range and alignment.
module tb_imem_arb;

  logic        clk;
  logic        rst_n;
  logic        if_req_valid, if_req_ready, if_rsp_valid, if_rsp_ready, if_rsp_err;
  logic [63:0] if_req_addr;
  logic [31:0] if_rsp_data;
  logic        dbg_req_valid, dbg_req_ready, dbg_rsp_valid, dbg_rsp_ready, dbg_rsp_err;
  logic [63:0] dbg_req_addr;
  logic [31:0] dbg_rsp_data;
  logic [63:0] rom_addr;
  logic [31:0] rom_dout;
  logic [31:0] rom_mem [0:4095];

  int checks = 0;
  int errors = 0;

  imem_arb #(.ADDR_W(64), .DATA_W(32), .DEPTH_LOG2(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
    .if_rsp_err(if_rsp_err),
    .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready), .dbg_req_addr(dbg_req_addr),
    .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready), .dbg_rsp_data(dbg_rsp_data),
    .dbg_rsp_err(dbg_rsp_err),
    .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  assign rom_dout = rom_mem[rom_addr[13:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full transaction from an IDLE cycle with rsp_ready high; returns in the next IDLE cycle.
  task automatic do_txn(input string tag, input logic use_dbg, input logic [63:0] addr,
                        input logic [31:0] exp_data, input logic exp_err);
    if_rsp_ready  = 1'b1;
    dbg_rsp_ready = 1'b1;
    if (use_dbg) begin
      dbg_req_valid = 1'b1;
      dbg_req_addr  = addr;
    end else begin
      if_req_valid = 1'b1;
      if_req_addr  = addr;
    end
    #1;
    chk({tag, "_req_ready"}, use_dbg ? dbg_req_ready : if_req_ready, 64'd1);
    @(negedge clk);
    if_req_valid  = 1'b0;
    dbg_req_valid = 1'b0;
    #1;
    chk({tag, "_rom_addr"}, rom_addr, addr);
    chk({tag, "_read_valid"}, use_dbg ? dbg_rsp_valid : if_rsp_valid, 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_rsp_valid"}, use_dbg ? dbg_rsp_valid : if_rsp_valid, 64'd1);
    chk({tag, "_rsp_data"}, use_dbg ? dbg_rsp_data : if_rsp_data, {32'd0, exp_data});
    chk({tag, "_rsp_err"}, use_dbg ? dbg_rsp_err : if_rsp_err, {63'd0, exp_err});
    chk({tag, "_other_valid"}, use_dbg ? if_rsp_valid : dbg_rsp_valid, 64'd0);
    chk({tag, "_other_data"}, use_dbg ? if_rsp_data : dbg_rsp_data, 64'd0);
    @(negedge clk);
    #1;
    chk({tag, "_rsp_done"}, use_dbg ? dbg_rsp_valid : if_rsp_valid, 64'd0);
  endtask

  initial begin
    logic exp_if;
    logic        al_err;
    logic [31:0] al_data;
    for (int i = 0; i < 4096; i++) begin
      rom_mem[i] = {4'h1, i[11:0], 4'h0, i[11:0]};
    end
    rom_mem[2] = 32'h0050_0093;

    rst_n = 1'b0;
    if_req_valid = 1'b0; if_req_addr = 64'd0; if_rsp_ready = 1'b0;
    dbg_req_valid = 1'b0; dbg_req_addr = 64'd0; dbg_rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_if_rsp_valid", if_rsp_valid, 64'd0);
    chk("rst_dbg_rsp_valid", dbg_rsp_valid, 64'd0);
    chk("rst_if_rsp_data", if_rsp_data, 64'd0);
    chk("rst_dbg_rsp_err", dbg_rsp_err, 64'd0);
    chk("rst_rom_addr", rom_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Contention: both ports request continuously, grants must alternate starting with IF.
    @(negedge clk);
    if_req_valid = 1'b1; if_req_addr = 64'h0;
    dbg_req_valid = 1'b1; dbg_req_addr = 64'h4;
    if_rsp_ready = 1'b1; dbg_rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      exp_if = (k % 2 == 0);
      #1;
      chk("cont_if_ready", if_req_ready, {63'd0, exp_if});
      chk("cont_dbg_ready", dbg_req_ready, {63'd0, !exp_if});
      @(negedge clk);
      #1;
      chk("cont_read_no_ready", {62'd0, if_req_ready, dbg_req_ready}, 64'd0);
      @(negedge clk);
      #1;
      chk("cont_if_rsp_valid", if_rsp_valid, {63'd0, exp_if});
      chk("cont_dbg_rsp_valid", dbg_rsp_valid, {63'd0, !exp_if});
      chk("cont_data", exp_if ? if_rsp_data : dbg_rsp_data,
          exp_if ? 64'h1000_0000 : 64'h1001_0001);
      chk("cont_resp_no_ready", {62'd0, if_req_ready, dbg_req_ready}, 64'd0);
      @(negedge clk);
    end
    if_req_valid = 1'b0;
    dbg_req_valid = 1'b0;

    do_txn("single_fetch", 1'b0, 64'h8, 32'h0050_0093, 1'b0);

    // Backpressure: DBG holds its response while IF waits.
    dbg_req_valid = 1'b1; dbg_req_addr = 64'h3FFC; dbg_rsp_ready = 1'b0;
    #1;
    chk("bp_dbg_ready", dbg_req_ready, 64'd1);
    @(negedge clk);
    dbg_req_valid = 1'b0;
    if_req_valid = 1'b1; if_req_addr = 64'h4000;
    #1;
    chk("bp_read_if_ready", if_req_ready, 64'd0);
    repeat (5) begin
      @(negedge clk);
      #1;
      chk("bp_hold_valid", dbg_rsp_valid, 64'd1);
      chk("bp_hold_data", dbg_rsp_data, 64'h1FFF_0FFF);
      chk("bp_hold_err", dbg_rsp_err, 64'd0);
      chk("bp_if_ready", if_req_ready, 64'd0);
    end
    @(negedge clk);
    dbg_rsp_ready = 1'b1;
    #1;
    chk("bp_hs_valid", dbg_rsp_valid, 64'd1);
    chk("bp_hs_if_ready", if_req_ready, 64'd0);
    @(negedge clk);
    #1;
    chk("bp_done_valid", dbg_rsp_valid, 64'd0);
    chk("bp_if_granted", if_req_ready, 64'd1);
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    chk("range_4000_rom_addr", rom_addr, 64'h4000);
    @(negedge clk);
    #1;
    chk("range_4000_valid", if_rsp_valid, 64'd1);
    chk("range_4000_data", if_rsp_data, 64'd0);
    chk("range_4000_err", if_rsp_err, 64'd1);
    @(negedge clk);

    do_txn("range_high", 1'b1, 64'h1_0000_0000, 32'h0, 1'b1);
    do_txn("range_top", 1'b0, 64'h3FFC, 32'h1FFF_0FFF, 1'b0);

`ifdef IMEM_ARB_ALIGN_CHECK_EN
    al_err = 1'b1; al_data = 32'h0;
`else
    al_err = 1'b0; al_data = 32'h1001_0001;
`endif
    do_txn("align_6", 1'b0, 64'h6, al_data, al_err);

    // Reset during RESP aborts the transaction.
    if_req_valid = 1'b1; if_req_addr = 64'h8;
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    #1;
    chk("mid_rst_pre_valid", if_rsp_valid, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", if_rsp_valid, 64'd0);
    chk("mid_rst_data", if_rsp_data, 64'd0);
    chk("mid_rst_rom_addr", rom_addr, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_if_valid", if_rsp_valid, 64'd0);
      chk("post_rst_dbg_valid", dbg_rsp_valid, 64'd0);
    end
    do_txn("post_rst_dbg", 1'b1, 64'h4, 32'h1001_0001, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
